avmm_hex_responder: RTL and testbench
=====================================

AVMM_HEX_RESPONDER -- requirements
Module: avmm_hex_responder

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BLINK_HZ, default 2, blink toggle rate in Hz.
REQ-003 SHALL have port clk, input, 1, sole clock.
REQ-004 SHALL have port reset_n, input, 1, reset (asynchronous, active-low).
REQ-005 SHALL have port address, input, 4, Avalon-MM word address.
REQ-006 SHALL have ports read and write, input, 1 each, Avalon-MM access strobes.
REQ-007 SHALL have port writedata, input, 32, write data.
REQ-008 SHALL have port readdata, output, 32, read data.
REQ-009 SHALL have port waitrequest, output, 1, Avalon-MM stall.
REQ-010 SHALL have ports hex0..hex5, output, 8 each, active-low segments; bit7 = DP, bits6:0 = g..a.

Function
REQ-011 SHALL implement FSM states IDLE and ACK: IDLE holds waitrequest=1; IDLE with read|write -> ACK; ACK holds waitrequest=0 and always returns to IDLE, giving exactly one wait state per access.
REQ-012 SHALL commit writes on the ACK-exit clock edge; readdata SHALL be valid during ACK and 0 in every other cycle.
REQ-013 SHALL treat read and write asserted together as a write only, with readdata=0.
REQ-014 SHALL return ACK to IDLE without side effects if read and write are both low during ACK (master withdrew).
REQ-015 Register map: 0-5 DIGITn (bits3:0 value, bit4 dp, bit5 blank, bit6 blink); 6 CTRL (bit0 enable); 7 STATUS read-only (bit0 blink phase, bits15:8 write count); 8-15 read 0, writes ignored; unused bits read 0.
REQ-016 SHALL increment the 8-bit write count on every committed write to addresses 0-6; it SHALL wrap 255 -> 0.
REQ-017 SHALL decode each value 0x0-0xF to standard hex 7-segment glyphs, active-low; hexN[7] = ~dp.
REQ-018 SHALL drive hexN = 8'hFF when blank=1, when CTRL.enable=0, or when blink=1 and blink phase=1.
REQ-019 SHALL register the hex outputs, so a register write is visible on hexN one cycle after commit.

Reset
REQ-020 SHALL reset asynchronously on reset_n low; the FSM goes to IDLE and waitrequest=1.
REQ-021 SHALL reset readdata=0, DIGITn=0x20 (blank), CTRL=0x1, write count=0, prescaler=0, phase=0, hexN=8'hFF.
REQ-022 SHALL abort an access in flight when reset occurs in ACK, with no register update.

Configuration
REQ-023 With macro HEX_BLINK_EN defined, SHALL implement a prescaler that toggles phase every CLK_HZ/(2*BLINK_HZ) cycles, wrapping to 0 on each toggle.
REQ-024 Without HEX_BLINK_EN, SHALL omit the prescaler; blink bits read 0 and have no effect, and STATUS bit0 reads 0.

Structure
REQ-025 SHALL place the register address constants, the DIGIT field bit positions and the 16-entry segment lookup constant in a shared package.
REQ-026 SHALL instantiate sub-module hex7seg_decode (4-bit value + dp -> 8-bit active-low segments) six times.

Verification
REQ-027 Reset release -> all hexN=8'hFF, waitrequest=1, and a read of address 6 returns 0x1.
REQ-028 Write 0x0A to address 0 -> waitrequest low exactly one cycle after write is asserted; hex0=8'h88 on the cycle after commit; a read of address 7 gives bits15:8=1.
REQ-029 Write 0x13 to address 2, then write 0x0 to address 6 -> hex2 goes 8'h30 -> 8'hFF; write 0x1 to address 6 -> hex2 returns to 8'h30.
REQ-030 HEX_BLINK_EN with CLK_HZ=8, BLINK_HZ=1; write 0x45 to address 1 -> hex1 alternates 8'h92 / 8'hFF every 4 cycles.
REQ-031 256 writes to address 3 -> STATUS bits15:8 = 0; a write to address 12 -> count unchanged and a read of address 12 returns 0.
REQ-032 Read and write asserted together at address 4 with data 0x7 -> readdata=0 in ACK and DIGIT4=0x7; reset_n pulsed low during ACK of a write -> the register keeps its reset value.

Source files
------------

// File: rtl/avmm_hex_responder_pkg.sv
// Shared constants for the Avalon-MM hex display responder: register map,
// DIGIT field positions, 7-segment glyph table and FSM state type.
package avmm_hex_responder_pkg;

    localparam int NUM_DIGITS = 6;

    // Word addresses; 0..5 are the DIGIT registers.
    localparam logic [3:0] ADDR_CTRL   = 4'd6;
    localparam logic [3:0] ADDR_STATUS = 4'd7;

    // DIGIT register fields (value lives in bits 3:0).
    localparam int DIG_DP    = 4;
    localparam int DIG_BLANK = 5;
    localparam int DIG_BLINK = 6;

    localparam logic [6:0] DIGIT_RST = 7'h20;

    // Active-low g..a glyphs, entry n is the glyph for hex value n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

endpackage

// File: rtl/avmm_hex_responder_hex7seg_decode.sv
// Single-digit decoder: 4-bit value plus decimal point to active-low segments.
module hex7seg_decode
    import avmm_hex_responder_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {~dp, SEG_LUT[value]};

endmodule

// File: rtl/avmm_hex_responder.sv
// Avalon-MM slave driving six 7-segment displays with one wait state per
// access. Optional blink support is built when HEX_BLINK_EN is defined.
module avmm_hex_responder
    import avmm_hex_responder_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [7:0]  hex0,
    output logic [7:0]  hex1,
    output logic [7:0]  hex2,
    output logic [7:0]  hex3,
    output logic [7:0]  hex4,
    output logic [7:0]  hex5
);

    state_t                            state;
    logic [NUM_DIGITS-1:0][6:0]        digit;
    logic                              enable;
    logic [7:0]                        wcnt;
    logic                              phase;
    logic [31:0]                       rd_mux;
    logic [NUM_DIGITS-1:0][7:0]        seg;
    logic [NUM_DIGITS-1:0][7:0]        hex_q;
    logic                              commit;
    logic                              unused_ok;

`ifdef HEX_BLINK_EN
    localparam int  PRESC    = (CLK_HZ / (2 * BLINK_HZ) > 1) ? CLK_HZ / (2 * BLINK_HZ) : 1;
    localparam int  PW       = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic BLINK_EN = 1'b1;

    logic [PW-1:0] presc;

    // Free-running prescaler; phase flips and the count wraps on terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            phase <= 1'b0;
        end else if (presc == PW'(PRESC - 1)) begin
            presc <= '0;
            phase <= ~phase;
        end else begin
            presc <= presc + PW'(1);
        end
    end
`else
    localparam logic BLINK_EN = 1'b0;

    logic [31:0] unused_cfg;

    assign phase      = 1'b0;
    assign unused_cfg = CLK_HZ ^ BLINK_HZ;
`endif

    assign unused_ok = ^writedata[31:7];

    // A write lands on the edge that leaves ACK; a withdrawn strobe commits nothing.
    assign commit = (state == ACK) && write;

    // Read mux; anything not mapped reads as zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: rd_mux = {25'd0, digit[address[2:0]]};
            ADDR_CTRL:   rd_mux = {31'd0, enable};
            ADDR_STATUS: rd_mux = {16'd0, wcnt, 7'd0, phase};
            default:     rd_mux = '0;
        endcase
    end

    // Handshake FSM: IDLE stalls, ACK releases for exactly one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            waitrequest <= 1'b1;
            readdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read || write) begin
                        state       <= ACK;
                        waitrequest <= 1'b0;
                        // Simultaneous read+write is a write; it returns zero.
                        readdata    <= (read && !write) ? rd_mux : '0;
                    end
                end
                ACK: begin
                    state       <= IDLE;
                    waitrequest <= 1'b1;
                    readdata    <= '0;
                end
                default: begin
                    state       <= IDLE;
                    waitrequest <= 1'b1;
                    readdata    <= '0;
                end
            endcase
        end
    end

    // Register file and write counter; STATUS and 8..15 ignore writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit  <= {NUM_DIGITS{DIGIT_RST}};
            enable <= 1'b1;
            wcnt   <= '0;
        end else if (commit) begin
            if (address < 4'd6)
                digit[address[2:0]] <= {writedata[DIG_BLINK] & BLINK_EN, writedata[5:0]};
            else if (address == ADDR_CTRL)
                enable <= writedata[0];
            if (address <= ADDR_CTRL)
                wcnt <= wcnt + 8'd1;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        hex7seg_decode u_dec (
            .value (digit[i][3:0]),
            .dp    (digit[i][DIG_DP]),
            .seg   (seg[i])
        );
    end

    // Registered display outputs with blank/disable/blink override.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_q <= {NUM_DIGITS{8'hFF}};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit[i][DIG_BLANK] || !enable || (digit[i][DIG_BLINK] && phase))
                    hex_q[i] <= 8'hFF;
                else
                    hex_q[i] <= seg[i];
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_avmm_hex_responder.sv
// Directed bench for avmm_hex_responder: vector table plus hand sequences
// for handshake timing, blink, counter wrap, read+write and reset abort.
module tb_avmm_hex_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [5:0][7:0] hexv;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign hexv = {hex5, hex4, hex3, hex2, hex1, hex0};

    avmm_hex_responder #(.CLK_HZ(8), .BLINK_HZ(1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .hex4        (hex4),
        .hex5        (hex5)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        int          hidx;     // -1: no display check
        logic [7:0]  exp_hex;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        while (waitrequest && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (waitrequest) check({name, "_timeout"}, 64'(waitrequest), 64'd0);
    endtask

    task automatic avmm_write(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        wait_ack("wr");
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic avmm_read(input logic [3:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clk);
        wait_ack("rd");
        d = readdata;
        @(negedge clk);
        read = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        logic [31:0] d;
        logic [7:0]  s[24];
        int          k, bad;

        vecs[0] = '{4'd0, 32'h1E,       0, 8'h06, 32'h1E};
        vecs[1] = '{4'd5, 32'h00,       5, 8'hC0, 32'h00};
        vecs[2] = '{4'd1, 32'h1F,       1, 8'h0E, 32'h1F};
        vecs[3] = '{4'd2, 32'h2C,       2, 8'hFF, 32'h2C};
        vecs[4] = '{4'd3, 32'hFFFFFF87, 3, 8'hF8, 32'h07};
        vecs[5] = '{4'd4, 32'h1B,       4, 8'h03, 32'h1B};
        vecs[6] = '{4'd9, 32'hFF,      -1, 8'h00, 32'h00};
        vecs[7] = '{4'd6, 32'hFE,       0, 8'hFF, 32'h00};
        vecs[8] = '{4'd6, 32'h03,       4, 8'h03, 32'h01};
        vecs[9] = '{4'd0, 32'h09,       0, 8'h90, 32'h09};

        // Reset state
        do_reset();
        check("rst_hex", 64'(hexv), 64'({6{8'hFF}}));
        check("rst_wait", 64'(waitrequest), 64'd1);
        check("rst_rdata", 64'(readdata), 64'd0);
        avmm_read(4'd6, d);
        check("rst_ctrl", 64'(d), 64'h1);
        check("rdata_idle_zero", 64'(readdata), 64'd0);
        avmm_read(4'd0, d);
        check("rst_digit0", 64'(d), 64'h20);

        // One wait state and hex latency on a write
        address = 4'd0; writedata = 32'h0A; write = 1'b1;
        check("wr_idle_wait", 64'(waitrequest), 64'd1);
        @(negedge clk);
        check("wr_ack_wait", 64'(waitrequest), 64'd0);
        @(negedge clk);
        write = 1'b0;
        check("wr_exit_wait", 64'(waitrequest), 64'd1);
        check("hex0_pre", 64'(hex0), 64'hFF);
        @(negedge clk);
        check("hex0_post", 64'(hex0), 64'h88);
        avmm_read(4'd7, d);
        check("status_cnt1", 64'(d[15:8]), 64'd1);

        // CTRL enable gates all digits
        avmm_write(4'd2, 32'h13);
        @(negedge clk);
        check("hex2_on", 64'(hex2), 64'h30);
        avmm_write(4'd6, 32'h0);
        @(negedge clk);
        check("hex2_disabled", 64'(hex2), 64'hFF);
        check("hex0_disabled", 64'(hex0), 64'hFF);
        avmm_write(4'd6, 32'h1);
        @(negedge clk);
        check("hex2_reenabled", 64'(hex2), 64'h30);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            avmm_write(vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            if (vecs[i].hidx >= 0)
                check($sformatf("vec%0d_hex", i), 64'(hexv[vecs[i].hidx]), 64'(vecs[i].exp_hex));
            avmm_read(vecs[i].addr, d);
            check($sformatf("vec%0d_rd", i), 64'(d), 64'(vecs[i].exp_rd));
        end
        avmm_read(4'd7, d);
        check("status_cnt13", 64'(d[15:8]), 64'd13);
        avmm_write(4'd7, 32'hFFFF);
        avmm_read(4'd7, d);
        check("status_ro", 64'(d[31:1]), 64'(32'd13 << 7));

        // Master withdraws the write during ACK
        address = 4'd0; writedata = 32'h05; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        repeat (2) @(negedge clk);
        avmm_read(4'd0, d);
        check("withdraw_digit", 64'(d), 64'h09);
        avmm_read(4'd7, d);
        check("withdraw_cnt", 64'(d[15:8]), 64'd13);

        // Blink
        avmm_write(4'd1, 32'h45);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            s[i] = hex1;
        end
`ifdef HEX_BLINK_EN
        k = 0;
        for (int i = 1; i < 6; i++)
            if (k == 0 && s[i] !== s[i-1]) k = i;
        check("blink_toggle_seen", 64'(k != 0), 64'd1);
        bad = 0;
        if (k != 0) begin
            for (int j = 0; j < 16; j++)
                if (s[k+j] !== ((((j / 4) % 2) == 0) ? s[k] : ((s[k] == 8'h92) ? 8'hFF : 8'h92)))
                    bad++;
            if (s[k] !== 8'h92 && s[k] !== 8'hFF) bad++;
        end
        check("blink_pattern", 64'(bad), 64'd0);
        avmm_read(4'd1, d);
        check("blink_rd", 64'(d), 64'h45);
`else
        k = 0;
        bad = 0;
        for (int i = 0; i < 24; i++)
            if (s[i] !== 8'h92) bad++;
        check("noblink_steady", 64'(bad), 64'd0);
        avmm_read(4'd1, d);
        check("noblink_rd", 64'(d), 64'h05);
        avmm_read(4'd7, d);
        check("noblink_phase", 64'(d[0]), 64'd0);
`endif

        // Write counter wrap and unmapped addresses
        do_reset();
        for (int i = 0; i < 256; i++)
            avmm_write(4'd3, 32'(i));
        avmm_read(4'd7, d);
        check("cnt_wrap", 64'(d[31:1]), 64'd0);
        avmm_write(4'd12, 32'h55);
        avmm_read(4'd7, d);
        check("cnt_unmapped", 64'(d[31:1]), 64'd0);
        avmm_read(4'd12, d);
        check("rd_unmapped", 64'(d), 64'd0);

        // Read and write together act as a write
        address = 4'd4; writedata = 32'h7; read = 1'b1; write = 1'b1;
        @(negedge clk);
        check("rw_ack", 64'(waitrequest), 64'd0);
        check("rw_rdata_zero", 64'(readdata), 64'd0);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        avmm_read(4'd4, d);
        check("rw_digit4", 64'(d), 64'h07);
        check("rw_hex4", 64'(hex4), 64'hF8);

        // Reset during ACK aborts the write
        address = 4'd5; writedata = 32'h3; write = 1'b1;
        @(negedge clk);
        check("abort_in_ack", 64'(waitrequest), 64'd0);
        #2;
        reset_n = 1'b0; write = 1'b0;
        #1;
        check("abort_async_wait", 64'(waitrequest), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        avmm_read(4'd5, d);
        check("abort_digit5", 64'(d), 64'h20);
        avmm_read(4'd7, d);
        check("abort_cnt", 64'(d[31:1]), 64'd0);
        check("abort_hex", 64'(hexv), 64'({6{8'hFF}}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
